fsm_sched: RTL and testbench
============================

# fsm_sched

Scheduler that shares the single `fsm` instance among `NREQ` requesters. It arbitrates requests, grants one requester at a time, and drives the fsm's `enable` for exactly the number of cycles the winner asked for. At the end of each run it captures the fsm's 4-bit `out` and returns it to the winner with a one-cycle `done` pulse. It sits between the requester blocks and the `enable` / `out` pins of `fsm`.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `LENW`, default 4: width of each run-length field.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  level request per requester; held high until that requester sees `done`.
- `len`  in  NREQ*LENW  run length of requester i at bits [i*LENW +: LENW]; sampled only on entry to GRANT.
- `fsm_out`  in  4  the fsm's `out` pins.
- `fsm_enable`  out  1  drives the fsm's `enable`.
- `gnt`  out  NREQ  one-hot grant.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  4  `fsm_out` captured at run end; held until the next capture.

## Operation
- States: IDLE, GRANT, RUN, DONE. All outputs are registered or decoded from state; there are no combinational paths from `req` to outputs.
- IDLE, any `req` bit high: the arbiter picks winner w.
  - Next state is GRANT.
  - `gnt[w]` goes high.
  - The down-counter `cnt` (LENW bits) loads `len` field w.
- GRANT:
  - `cnt` == 0 → DONE (zero-length run: fsm is never enabled).
  - Otherwise → RUN.
- RUN:
  - `fsm_enable` = 1 and `cnt` decrements each cycle.
  - Leave for DONE on the edge where `cnt` == 1.
  - This gives exactly `len` cycles with `fsm_enable` high.
- DONE:
  - `done` = 1 and `fsm_enable` = 0.
  - `result` is loaded from `fsm_out` on the edge entering DONE, so it reflects the fsm after its last enabled edge.
  - Next state is always IDLE.
- `gnt[w]` stays high from GRANT through DONE inclusive and drops on entry to IDLE.
- Requests are ignored outside IDLE. If the winner drops `req` mid-run, the run still completes and `done` still pulses. `len` changes after GRANT have no effect.
- Arbitration uses the `last` register, which holds the index of the most recently granted requester. Its reset value is NREQ-1, so `req[0]` wins first.

## Timing
- Request seen in IDLE at edge 0:
  - `gnt` high from cycle 1.
  - `fsm_enable` high cycles 2..len+1.
  - `done` in cycle len+2.
  - IDLE at cycle len+3.
- Total occupancy is len+3 cycles, or 3 cycles when len=0.
- Back-to-back: a new grant can start in the first IDLE cycle after DONE. There is no dead cycle beyond IDLE itself.
- Maximum run is 2^LENW-1 enabled cycles. `cnt` never wraps.
- Reset, asynchronous, at any point including mid-RUN:
  - State goes to IDLE.
  - `gnt`, `fsm_enable`, `busy`, `done`, `result`, `cnt` all go to 0.
  - `last` goes to NREQ-1.
  - `fsm_enable` drops immediately. The first grant after reset is possible on the first edge with `rstb` high.

## Configuration
- `FSM_SCHED_RR_EN` defined: round-robin arbitration.
  - Search starts at index `last`+1, mod NREQ.
  - `last` updates to w on each grant.
- Not defined: fixed priority, lowest index wins.
  - `last` is not implemented.
  - `req[0]` held continuously starves all other requesters.

## Test plan
- Reset, then `req`=4'b0001 with len0=5: `gnt`=0001 from cycle 1. `fsm_enable` is high exactly 5 cycles. `done` pulses at cycle 7 and `result` equals `fsm_out` sampled at that edge.
- len0=0: `gnt` high cycles 1-2, `fsm_enable` never high, `done` at cycle 2, `result` = current `fsm_out`.
- `req`=4'b1111 held, all len=1, RR enabled: grant order 0,1,2,3,0, each run 4 cycles. Without the macro: grants 0,0,0.
- `rstb` pulsed low during RUN with len=10: `fsm_enable`, `gnt`, `busy` go to 0 asynchronously with no `done`. After release, the next grant goes to `req[0]`.
- Winner drops `req` mid-RUN and another `req` rises: the current run completes its full `len`. The new requester is granted the cycle after returning to IDLE.
- len=15, the maximum: exactly 15 `fsm_enable` cycles, with no counter wrap.

Source files
------------

// File: rtl/fsm_sched.sv
`timescale 1ns/1ps
// fsm_sched -- shares one fsm instance among NREQ requesters.
//
// A winner is picked from the pending requests and granted. Then the fsm's
// enable is driven for exactly the requested number of cycles. The fsm's
// 4-bit output is captured into result, and done pulses for one cycle.
//
// Build option:
//   FSM_SCHED_RR_EN  defined   -> round-robin arbitration. The search starts
//                                 one past the last granted index.
//                    undefined -> fixed priority. The lowest index wins.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   LENW  width of each run-length field
//
// Ports:
//   clk         system clock, rising edge
//   rstb        asynchronous active-low reset
//   req         level request per requester, held until done
//   len         run length of requester i at [i*LENW +: LENW]
//   fsm_out     the fsm's out pins
//   fsm_enable  drives the fsm's enable (high only in RUN)
//   gnt         one-hot grant, high from GRANT through DONE
//   busy        high in any state other than IDLE
//   done        one-cycle completion pulse
//   result      fsm_out captured on the edge entering DONE
module fsm_sched #(
   parameter int NREQ = 4,
   parameter int LENW = 4
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LENW-1:0] len,
   input  logic [3:0]           fsm_out,
   output logic                 fsm_enable,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           result
);

   localparam int IDXW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [LENW-1:0]   cnt;
   logic [LENW-1:0]   len_arr [NREQ];
   logic              found;
   logic [IDXW-1:0]   win;
   logic [IDXW-1:0]   idx;
   logic [NREQ-1:0]   win_onehot;

   for (genvar g = 0; g < NREQ; g++) begin : g_len
      assign len_arr[g] = len[g*LENW +: LENW];
   end

`ifdef FSM_SCHED_RR_EN
   logic [IDXW-1:0]   last;

   // Rotating search: the candidate at offset k is (last + 1 + k) mod NREQ.
   // The first hit wins.
   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDXW'((int'(last) + 1 + k) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
`else
   // Fixed priority: scanning down from the top leaves the lowest set index.
   always_comb begin
      found = |req;
      win   = '0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDXW'(k);
         if (req[idx]) win = idx;
      end
   end
`endif

   always_comb begin
      win_onehot      = '0;
      win_onehot[win] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = GRANT;
         GRANT:   state_nxt = (cnt == '0) ? DONE : RUN;
         RUN:     if (cnt == LENW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         gnt    <= '0;
         cnt    <= '0;
         result <= '0;
`ifdef FSM_SCHED_RR_EN
         last   <= IDXW'(NREQ - 1);
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gnt <= win_onehot;
                  cnt <= len_arr[win];
`ifdef FSM_SCHED_RR_EN
                  last <= win;
`endif
               end
            end
            // The transition to DONE happens on the edge where cnt is 1.
            // That edge also brings cnt to 0, so it never wraps.
            RUN:     cnt <= cnt - LENW'(1);
            DONE:    gnt <= '0;
            default: ;
         endcase
         // Capture on the edge entering DONE. This is after the last
         // enabled fsm edge, or straight from GRANT for a zero-length run.
         if (state_nxt == DONE && state != DONE) result <= fsm_out;
      end
   end

   assign fsm_enable = (state == RUN);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_fsm_sched.sv
`timescale 1ns/1ps
// tb_fsm_sched -- directed testbench for fsm_sched (NREQ=4, LENW=4).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Cycle c is the cycle that follows edge c-1. The request is first seen at
// edge 0.
module tb_fsm_sched;

   logic        clk;
   logic        rstb;
   logic [3:0]  req;
   logic [15:0] len;
   logic [3:0]  fsm_out;
   logic        fsm_enable;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [3:0]  result;

   int n_cmp = 0;
   int n_bad = 0;

   fsm_sched #(.NREQ(4), .LENW(4)) dut (
      .clk(clk), .rstb(rstb), .req(req), .len(len), .fsm_out(fsm_out),
      .fsm_enable(fsm_enable), .gnt(gnt), .busy(busy), .done(done),
      .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps through one complete transaction. It starts in an IDLE cycle with
   // req already set, and returns in the following IDLE cycle, bounded to 40
   // cycles. fsm_out is driven as 4'hA ^ c during cycle c. When drop is set,
   // the winner lowers its req in the done cycle.
   task automatic observe(input bit drop, output logic [3:0] g1, output int n_en,
                          output int first_en, output int done_at, output int idle_at,
                          output bit gnt_stable, output logic [3:0] res_done);
      n_en = 0; first_en = -1; done_at = -1; idle_at = -1; gnt_stable = 1'b1;
      res_done = 'x;
      fsm_out = 4'hA;
      tick();
      g1 = gnt;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) tick();
         if (!busy) begin
            idle_at = c;
            break;
         end
         if (fsm_enable) begin
            n_en++;
            if (first_en < 0) first_en = c;
         end
         if (gnt !== g1) gnt_stable = 1'b0;
         if (done && done_at < 0) begin
            done_at  = c;
            res_done = result;
            if (drop) req = req & ~gnt;
         end
         fsm_out = 4'hA ^ 4'(c);
      end
   endtask

   task automatic apply_reset();
      rstb = 1'b0; req = '0; len = '0; fsm_out = '0;
      tick();
      tick();
      rstb = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (fsm_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b want 0", fsm_enable); end
      n_cmp++; if (result !== 4'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
   endtask

   task automatic test_basic_run();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      len[3:0] = 4'd5; req = 4'b0001;
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (g1 !== 4'b0001) begin n_bad++; $display("FAIL basic_gnt: got %b want 0001", g1); end
      n_cmp++; if (ne !== 5) begin n_bad++; $display("FAIL basic_en_cycles: got %0d want 5", ne); end
      n_cmp++; if (fe !== 2) begin n_bad++; $display("FAIL basic_first_en: got %0d want 2", fe); end
      n_cmp++; if (da !== 7) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 7", da); end
      n_cmp++; if (ia !== 8) begin n_bad++; $display("FAIL basic_idle_cycle: got %0d want 8", ia); end
      n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL basic_gnt_stable: got %b want 1", gs); end
      n_cmp++; if (rd !== 4'hC) begin n_bad++; $display("FAIL basic_result: got %h want c", rd); end
      fsm_out = 4'h3;
      tick();
      n_cmp++; if (result !== 4'hC) begin n_bad++; $display("FAIL basic_result_hold: got %h want c", result); end
   endtask

   task automatic test_zero_len();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      len[3:0] = 4'd0; req = 4'b0001;
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (g1 !== 4'b0001) begin n_bad++; $display("FAIL zero_gnt: got %b want 0001", g1); end
      n_cmp++; if (ne !== 0) begin n_bad++; $display("FAIL zero_en_cycles: got %0d want 0", ne); end
      n_cmp++; if (da !== 2) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 2", da); end
      n_cmp++; if (ia !== 3) begin n_bad++; $display("FAIL zero_idle_cycle: got %0d want 3", ia); end
      n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL zero_gnt_stable: got %b want 1", gs); end
      n_cmp++; if (rd !== 4'hB) begin n_bad++; $display("FAIL zero_result: got %h want b", rd); end
   endtask

   task automatic test_max_len();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      len[3:0] = 4'd15; req = 4'b0001;
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (ne !== 15) begin n_bad++; $display("FAIL max_en_cycles: got %0d want 15", ne); end
      n_cmp++; if (da !== 17) begin n_bad++; $display("FAIL max_done_cycle: got %0d want 17", da); end
      n_cmp++; if (ia !== 18) begin n_bad++; $display("FAIL max_idle_cycle: got %0d want 18", ia); end
      n_cmp++; if (rd !== 4'hA) begin n_bad++; $display("FAIL max_result: got %h want a", rd); end
   endtask

   task automatic test_arbitration();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      logic [3:0] exp_seq [5];
`ifdef FSM_SCHED_RR_EN
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      apply_reset();
      len = 16'h1111; req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         observe(1'b0, g1, ne, fe, da, ia, gs, rd);
         n_cmp++; if (g1 !== exp_seq[i]) begin n_bad++; $display("FAIL arb_gnt_%0d: got %b want %b", i, g1, exp_seq[i]); end
         n_cmp++; if (ne !== 1) begin n_bad++; $display("FAIL arb_en_%0d: got %0d want 1", i, ne); end
         n_cmp++; if (ia !== 4) begin n_bad++; $display("FAIL arb_occupancy_%0d: got %0d want 4", i, ia); end
      end
      req = '0;
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      len = 16'h000A; req = 4'b0001;
      tick(); tick(); tick();
      n_cmp++; if (fsm_enable !== 1'b1) begin n_bad++; $display("FAIL rst_pre_enable: got %b want 1", fsm_enable); end
      rstb = 1'b0;
      #1;
      n_cmp++; if (fsm_enable !== 1'b0) begin n_bad++; $display("FAIL rst_async_enable: got %b want 0", fsm_enable); end
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_async_gnt: got %b want 0000", gnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
      n_cmp++; if (result !== 4'h0) begin n_bad++; $display("FAIL rst_async_result: got %h want 0", result); end
      req = 4'b0011; len = 16'h0032;
      tick(); tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done: got %b want 0", done); end
      rstb = 1'b1;
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (g1 !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 0001", g1); end
      n_cmp++; if (ne !== 2) begin n_bad++; $display("FAIL rst_first_en: got %0d want 2", ne); end
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (g1 !== 4'b0010) begin n_bad++; $display("FAIL rst_second_gnt: got %b want 0010", g1); end
      n_cmp++; if (ne !== 3) begin n_bad++; $display("FAIL rst_second_en: got %0d want 3", ne); end
      n_cmp++; if (ia !== 6) begin n_bad++; $display("FAIL rst_second_idle: got %0d want 6", ia); end
   endtask

   task automatic test_drop_mid_run();
      logic [3:0] g1, rd; int ne, fe, da, ia; bit gs;
      int n_run = 0;
      int done_c = -1;
      logic [3:0] first_gnt = 'x;
      len = 16'h0206; req = 4'b0001;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 1) first_gnt = gnt;
         if (fsm_enable) n_run++;
         if (done) begin
            done_c = c;
            break;
         end
         // Winner drops, another requester rises, and len0 changes.
         if (c == 3) begin
            req = 4'b0100;
            len[3:0] = 4'd1;
         end
      end
      n_cmp++; if (first_gnt !== 4'b0001) begin n_bad++; $display("FAIL drop_gnt: got %b want 0001", first_gnt); end
      n_cmp++; if (n_run !== 6) begin n_bad++; $display("FAIL drop_en_cycles: got %0d want 6", n_run); end
      n_cmp++; if (done_c !== 8) begin n_bad++; $display("FAIL drop_done_cycle: got %0d want 8", done_c); end
      tick();
      n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL drop_idle: got busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt); end
      observe(1'b1, g1, ne, fe, da, ia, gs, rd);
      n_cmp++; if (g1 !== 4'b0100) begin n_bad++; $display("FAIL drop_next_gnt: got %b want 0100", g1); end
      n_cmp++; if (ne !== 2) begin n_bad++; $display("FAIL drop_next_en: got %0d want 2", ne); end
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_zero_len();
      test_max_len();
      test_arbitration();
      test_reset_mid_run();
      test_drop_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
